// File: rtl/sys_arr_pkg.sv
// Shared types and sizing helpers for the N x N weight-stationary systolic core.
package sys_arr_pkg;

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    COMPUTE = 2'd1,
    DRAIN   = 2'd2
  } state_e;

  // Accept-to-out_valid latency in cycles.
  function automatic int LAT(input int n);
    return 2 * n;
  endfunction

  // In-flight counter width: holds 0..2N.
  function automatic int cnt_w(input int n);
    return $clog2(2 * n + 1);
  endfunction

endpackage

// File: rtl/sys_arr_pe.sv
// Single MAC cell: stationary weight, registered activation pass-through and partial sum.
// SYS_ARR_SAT_EN selects a saturating accumulate instead of modulo-2^ACC_W wrap.
module sys_arr_pe
  import sys_arr_pkg::*;
#(
  parameter int DATA_W   = 4,
  parameter int WEIGHT_W = 4,
  parameter int ACC_W    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                w_we,
  input  logic [WEIGHT_W-1:0] w_in,
  input  logic [DATA_W-1:0]   x_in,
  input  logic [ACC_W-1:0]    sum_in,
  output logic [DATA_W-1:0]   x_out,
  output logic [ACC_W-1:0]    sum_out
);
  localparam int PW = DATA_W + WEIGHT_W;

  logic [WEIGHT_W-1:0] w_q;
  logic [PW-1:0]       prod_full;
  logic [ACC_W-1:0]    prod;
  logic [ACC_W-1:0]    sum_nxt;

  assign prod_full = PW'(x_in) * PW'(w_q);
  assign prod      = ACC_W'(prod_full);

`ifdef SYS_ARR_SAT_EN
  logic [ACC_W:0] sum_wide;
  assign sum_wide = {1'b0, sum_in} + {1'b0, prod};
  // A carry out pins the sum at full scale; later rows cannot pull it back down.
  assign sum_nxt  = sum_wide[ACC_W] ? '1 : sum_wide[ACC_W-1:0];
`else
  assign sum_nxt  = sum_in + prod;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      w_q     <= '0;
      x_out   <= '0;
      sum_out <= '0;
    end else begin
      if (w_we) w_q <= w_in;
      x_out   <= x_in;
      sum_out <= sum_nxt;
    end
  end

endmodule

// File: rtl/sys_arr_nxn_core.sv
// N x N weight-stationary systolic MAC core: row-wise weight load, input skew, output deskew,
// reload/drain sequencing. Optional macro SYS_ARR_SAT_EN makes every PE add saturate.
module sys_arr_nxn_core
  import sys_arr_pkg::*;
#(
  parameter int N        = 4,
  parameter int DATA_W   = 4,
  parameter int WEIGHT_W = 4,
  parameter int ACC_W    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  w_valid,
  output logic                  w_ready,
  input  logic [N*WEIGHT_W-1:0] w_row,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [N*DATA_W-1:0]   in_vec,
  input  logic                  reload,
  output logic                  out_valid,
  output logic [N*ACC_W-1:0]    out_vec,
  output logic                  busy
);
  localparam int L  = LAT(N);
  localparam int CW = cnt_w(N);
  localparam int RW = $clog2(N);

  state_e                        state, state_nxt;
  logic [RW-1:0]                 rowcnt;
  logic [CW-1:0]                 cnt;
  logic                          w_fire, in_fire, last_row;
  logic [L:0]                    vld_pipe;
  logic [N-1:0]                  w_we;
  logic [N-1:0][DATA_W-1:0]      row_x;
  logic [N-1:0][N:0][DATA_W-1:0] xh;
  logic [N:0][N-1:0][ACC_W-1:0]  sv;
  logic [N-1:0][ACC_W-1:0]       col_out;
  logic [N-1:0][DATA_W-1:0]      x_tail;
  logic                          unused_x_tail;

  assign w_fire   = w_valid & w_ready;
  assign in_fire  = in_valid & in_ready;
  assign last_row = (rowcnt == RW'(N - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= LOAD;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    w_ready   = 1'b0;
    in_ready  = 1'b0;
    case (state)
      LOAD: begin
        w_ready = 1'b1;
        if (w_valid && last_row) state_nxt = COMPUTE;
      end
      COMPUTE: begin
        in_ready = 1'b1;
        if (reload) state_nxt = DRAIN;
      end
      DRAIN:   if (cnt == '0) state_nxt = LOAD;
      default: state_nxt = LOAD;
    endcase
  end

  // vld_pipe[k] set means the vector accepted k cycles ago is at stage k.
  always_ff @(posedge clk) begin
    if (rst) begin
      rowcnt   <= '0;
      cnt      <= '0;
      vld_pipe <= '0;
    end else begin
      if (w_fire) rowcnt <= last_row ? '0 : rowcnt + RW'(1);
      vld_pipe <= {vld_pipe[L-1:0], in_fire};
      if (in_fire && !out_valid)      cnt <= cnt + CW'(1);
      else if (!in_fire && out_valid) cnt <= cnt - CW'(1);
    end
  end

  assign out_valid = vld_pipe[L];
  assign busy      = (cnt != '0);

  // Lane i passes i+1 registers so row i sees its element i cycles after row 0.
  for (genvar i = 0; i < N; i++) begin : g_skew
    logic [i:0][DATA_W-1:0] sk;
    always_ff @(posedge clk) begin
      if (rst) begin
        sk <= '0;
      end else begin
        sk[0] <= in_fire ? in_vec[i*DATA_W +: DATA_W] : '0;
        for (int k = 1; k <= i; k++) sk[k] <= sk[k-1];
      end
    end
    assign row_x[i] = sk[i];
    assign w_we[i]  = w_fire && (rowcnt == RW'(i));
  end

  assign sv[0] = '0;

  for (genvar i = 0; i < N; i++) begin : g_row
    assign xh[i][0]  = row_x[i];
    assign x_tail[i] = xh[i][N];
    for (genvar j = 0; j < N; j++) begin : g_col
      sys_arr_pe #(
        .DATA_W  (DATA_W),
        .WEIGHT_W(WEIGHT_W),
        .ACC_W   (ACC_W)
      ) u_pe (
        .clk    (clk),
        .rst    (rst),
        .w_we   (w_we[i]),
        .w_in   (w_row[j*WEIGHT_W +: WEIGHT_W]),
        .x_in   (xh[i][j]),
        .sum_in (sv[i][j]),
        .x_out  (xh[i][j+1]),
        .sum_out(sv[i+1][j])
      );
    end
  end

  assign unused_x_tail = ^x_tail;

  // Column j leaves the array j cycles after column 0; pad it back into alignment.
  for (genvar j = 0; j < N; j++) begin : g_dsk
    if (j < N - 1) begin : g_dly
      localparam int D = N - 1 - j;
      logic [D-1:0][ACC_W-1:0] ds;
      always_ff @(posedge clk) begin
        if (rst) begin
          ds <= '0;
        end else begin
          ds[0] <= sv[N][j];
          for (int k = 1; k < D; k++) ds[k] <= ds[k-1];
        end
      end
      assign col_out[j] = ds[D-1];
    end else begin : g_thru
      assign col_out[j] = sv[N][j];
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                out_vec <= '0;
    else if (vld_pipe[L-1]) out_vec <= col_out;
  end

endmodule

// File: tb/tb_sys_arr_nxn_core.sv
// Self-checking bench for sys_arr_nxn_core: directed test-plan scenarios plus random traffic,
// scored against a transaction-level model of y = x*W with a 2N-cycle result schedule.
module tb_sys_arr_nxn_core;
  localparam int N        = 4;
  localparam int DATA_W   = 4;
  localparam int WEIGHT_W = 4;
  localparam int ACC_W    = 8;
  localparam int LATV     = 2 * N;
`ifdef SYS_ARR_SAT_EN
  localparam logic [N*ACC_W-1:0] OVF = {N{8'd255}};
`else
  localparam logic [N*ACC_W-1:0] OVF = {N{8'd132}};
`endif

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  w_valid = 1'b0;
  logic                  w_ready;
  logic [N*WEIGHT_W-1:0] w_row = '0;
  logic                  in_valid = 1'b0;
  logic                  in_ready;
  logic [N*DATA_W-1:0]   in_vec = '0;
  logic                  reload = 1'b0;
  logic                  out_valid;
  logic [N*ACC_W-1:0]    out_vec;
  logic                  busy;

  sys_arr_nxn_core #(
    .N(N), .DATA_W(DATA_W), .WEIGHT_W(WEIGHT_W), .ACC_W(ACC_W)
  ) dut (
    .clk(clk), .rst(rst),
    .w_valid(w_valid), .w_ready(w_ready), .w_row(w_row),
    .in_valid(in_valid), .in_ready(in_ready), .in_vec(in_vec),
    .reload(reload),
    .out_valid(out_valid), .out_vec(out_vec), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errs = 0, checks = 0, n_out = 0;

  typedef struct {
    int                 due;
    logic [N*ACC_W-1:0] y;
  } exp_t;

  exp_t               exp_q[$];
  int                 m_mode = 0;   // 0 loading weights, 1 computing, 2 draining
  int                 m_rows = 0;
  int                 m_w[N][N];
  logic [N*ACC_W-1:0] m_out = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [N*ACC_W-1:0] ref_y(input logic [N*DATA_W-1:0] x);
    logic [N*ACC_W-1:0] y;
    int tot;
    y = '0;
    for (int j = 0; j < N; j++) begin
      tot = 0;
      for (int i = 0; i < N; i++) tot += int'(x[i*DATA_W +: DATA_W]) * m_w[i][j];
`ifdef SYS_ARR_SAT_EN
      if (tot > 2**ACC_W - 1) tot = 2**ACC_W - 1;
`else
      tot = tot % (2**ACC_W);
`endif
      y[j*ACC_W +: ACC_W] = ACC_W'(tot);
    end
    return y;
  endfunction

  // Samples on the falling edge: checks outputs of the last rising edge, then
  // folds in the inputs that the next rising edge will act on.
  task automatic monitor();
    exp_t e;
    int   nxt_mode, qn;
    bit   has_out;
    forever begin
      @(negedge clk);
      qn      = exp_q.size();
      has_out = (qn != 0) && (exp_q[0].due == cyc);
      chk("out_valid", out_valid, has_out);
      chk("busy", busy, qn != 0);
      chk("w_ready", w_ready, m_mode == 0);
      chk("in_ready", in_ready, m_mode == 1);
      if (out_valid) n_out++;
      if (has_out) begin
        m_out = exp_q[0].y;
        void'(exp_q.pop_front());
      end
      chk("out_vec", out_vec, m_out);
      nxt_mode = m_mode;
      case (m_mode)
        0: if (w_valid) begin
          for (int j = 0; j < N; j++) m_w[m_rows][j] = int'(w_row[j*WEIGHT_W +: WEIGHT_W]);
          m_rows++;
          if (m_rows == N) begin m_rows = 0; nxt_mode = 1; end
        end
        1: begin
          if (in_valid) begin
            e.due = cyc + 1 + LATV;
            e.y   = ref_y(in_vec);
            exp_q.push_back(e);
          end
          if (reload) nxt_mode = 2;
        end
        default: if (qn == 0) nxt_mode = 0;
      endcase
      if (rst) begin
        exp_q.delete();
        nxt_mode = 0;
        m_rows   = 0;
        m_out    = '0;
        for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) m_w[i][j] = 0;
      end
      m_mode = nxt_mode;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N*WEIGHT_W-1:0] rnd_w();
    return (N*WEIGHT_W)'($urandom);
  endfunction

  function automatic logic [N*DATA_W-1:0] rnd_x();
    return (N*DATA_W)'($urandom);
  endfunction

  task automatic load_row(input logic [N*WEIGHT_W-1:0] r);
    w_valid = 1'b1; w_row = r; tick(); w_valid = 1'b0;
  endtask

  task automatic send(input logic [N*DATA_W-1:0] x);
    in_valid = 1'b1; in_vec = x; tick(); in_valid = 1'b0;
  endtask

  task automatic wait_out(input int lim);
    int n = 0;
    while (!out_valid && n < lim) begin tick(); n++; end
    chk("wait_out", out_valid, 1);
  endtask

  task automatic wait_wready(input int lim);
    int n = 0;
    while (!w_ready && n < lim) begin tick(); n++; end
    chk("wait_w_ready", w_ready, 1);
  endtask

  task automatic wait_idle(input int lim);
    int n = 0;
    while (busy && n < lim) begin tick(); n++; end
    chk("wait_idle", busy, 0);
  endtask

  task automatic do_reload();
    reload = 1'b1; tick(); reload = 1'b0;
    wait_wready(40);
  endtask

  initial begin
    int t0, n0;
    fork monitor(); join_none

    repeat (2) tick();
    rst = 1'b0;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_vec", out_vec, 0);
    chk("rst_busy", busy, 0);
    chk("rst_w_ready", w_ready, 1);
    chk("rst_in_ready", in_ready, 0);

    // Test-plan weights, then identity vector with latency measurement.
    load_row(16'h4825); load_row(16'h9271); load_row(16'h3154); load_row(16'h1632);
    chk("load_in_ready", in_ready, 1);
    chk("load_w_ready", w_ready, 0);
    send(16'h0001);
    t0 = cyc;
    wait_out(20);
    chk("id_latency", cyc - t0, LATV);
    chk("id_y", out_vec, 32'h04080205);
    tick();
    chk("id_pulse", out_valid, 0);

    // Four back-to-back all-ones vectors.
    repeat (4) send(16'h1111);
    wait_out(20);
    for (int k = 0; k < 4; k++) begin
      chk("ones_valid", out_valid, 1);
      chk("ones_y", out_vec, 32'h1111110C);
      chk("ones_busy", busy, 1);
      tick();
    end
    chk("ones_gap", out_valid, 0);
    chk("ones_busy_drop", busy, 0);

    // Weight beats offered during compute must not disturb the weights.
    w_valid = 1'b1; w_row = rnd_w();
    repeat (3) send(rnd_x());
    w_valid = 1'b0;
    wait_idle(40);

    // Reload with three vectors in flight and a fourth accepted on the reload beat.
    repeat (3) send(rnd_x());
    n0 = n_out;
    in_valid = 1'b1; in_vec = rnd_x(); reload = 1'b1; tick();
    reload = 1'b0; in_vec = rnd_x();
    wait_wready(40);
    in_valid = 1'b0;
    chk("reload_results", n_out - n0, 4);
    chk("reload_in_ready", in_ready, 0);
    repeat (N) load_row(rnd_w());
    send(rnd_x()); send(rnd_x());
    wait_idle(40);

    // Overflow: full-scale weights and activations.
    do_reload();
    repeat (N) load_row('1);
    send('1);
    wait_out(20);
    chk("ovf_y", out_vec, OVF);
    wait_idle(40);

    // Partial load keeps the activation port closed.
    do_reload();
    load_row(rnd_w()); load_row(rnd_w());
    in_valid = 1'b1; in_vec = rnd_x();
    for (int k = 0; k < 3; k++) begin
      chk("partial_in_ready", in_ready, 0);
      tick();
    end
    in_valid = 1'b0;
    load_row(rnd_w()); load_row(rnd_w());
    chk("partial_done", in_ready, 1);

    // Reset with two vectors in flight.
    send(rnd_x()); send(rnd_x()); tick();
    n0 = n_out;
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rstmid_out_valid", out_valid, 0);
    chk("rstmid_out_vec", out_vec, 0);
    chk("rstmid_busy", busy, 0);
    chk("rstmid_w_ready", w_ready, 1);
    chk("rstmid_in_ready", in_ready, 0);
    repeat (LATV + 4) tick();
    chk("rstmid_no_out", n_out - n0, 0);

    // Random traffic across load, compute and drain.
    for (int c = 0; c < 800; c++) begin
      in_valid = ($urandom % 4) != 0;
      in_vec   = rnd_x();
      w_valid  = ($urandom % 2) == 1;
      w_row    = rnd_w();
      reload   = ($urandom % 50) == 0;
      tick();
    end
    in_valid = 1'b0; w_valid = 1'b0; reload = 1'b0;
    wait_idle(60);
    tick();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
